// File: rtl/axis_switch_rr_pkg.sv
// Shared types and the round-robin pick helper for the axis_switch_rr slice.
package axis_sw_pkg;

  localparam int MAX_SI = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // First set request after last_grant, scanning upward modulo num_si.
  function automatic int unsigned rr_pick(input logic [MAX_SI-1:0] req,
                                          input int unsigned       last_grant,
                                          input int unsigned       num_si);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    logic        hit;
    pick  = last_grant;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_SI; k++) begin
      idx   = (last_grant + k) % num_si;
      hit   = !found && (k <= num_si) &&
              (((req >> idx) & {{(MAX_SI-1){1'b0}}, 1'b1}) != {MAX_SI{1'b0}});
      pick  = hit ? idx : pick;
      found = found | hit;
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_switch_rr_if.sv
// Bundle of N AXI4-Stream lanes; the switch uses N=NUM_SI on the slave side and N=1 on the master side.
interface axis_switch_rr_if #(
  parameter int N     = 1,
  parameter int DATAW = 24
);

  logic [N*DATAW-1:0]   tdata;
  logic [N-1:0]         tvalid;
  logic [N-1:0]         tready;
  logic [N-1:0]         tuser;
  logic [N-1:0]         tlast;
  logic [N-1:0]         tid;
  logic [N-1:0]         tdest;
  logic [N*DATAW/8-1:0] tstrb;
  logic [N*DATAW/8-1:0] tkeep;

  modport master (output tdata, tvalid, tuser, tlast, tid, tdest, tstrb, tkeep,
                  input  tready);

  modport slave  (input  tdata, tvalid, tuser, tlast, tid, tdest, tstrb, tkeep,
                  output tready);

endinterface

// File: rtl/axis_switch_rr_skid_buf.sv
// axis_skid_buf: 2-entry register slice; ready depends only on occupancy, so it breaks
// both the data and the ready path while keeping one beat per cycle.
module axis_skid_buf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data
);

  logic [1:0]       count_q, count_d;
  logic [DATAW-1:0] head_q, head_d, tail_q, tail_d;
  logic             push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = in_data;
        end else begin
          tail_d = in_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= 2'd0;
      head_q  <= {DATAW{1'b0}};
      tail_q  <= {DATAW{1'b0}};
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/axis_switch_rr.sv
// axis_switch_rr: N-to-1 AXI4-Stream switch with packet-aware round-robin arbitration.
// Define AXIS_SW_OUTREG_EN to register all m_axis outputs through axis_skid_buf (+1 cycle).
module axis_switch_rr
  import axis_sw_pkg::*;
#(
  parameter  int NUM_SI = 3,
  parameter  int DATAW  = 24,
  localparam int IDXW   = $clog2(NUM_SI)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [NUM_SI-1:0] s_en,
  axis_switch_rr_if.slave   s_axis,
  axis_switch_rr_if.master  m_axis,
  output logic [IDXW-1:0]   grant_idx,
  output logic              busy
);

  localparam int STRBW = DATAW / 8;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   last_grant_q, last_grant_d;
  logic              busy_q, busy_d;
  logic [NUM_SI-1:0] req;
  logic [NUM_SI-1:0] s_ready;
  logic [IDXW-1:0]   rr_next;
  logic              take;
  logic              beat_done;
  logic              sel_valid, sel_user, sel_last, sel_id, sel_dest;
  logic [DATAW-1:0]  sel_data;
  logic [STRBW-1:0]  sel_strb, sel_keep;

  assign req     = s_en & s_axis.tvalid;
  assign rr_next = IDXW'(rr_pick(MAX_SI'(req), 32'(last_grant_q), NUM_SI));

  // Granted-lane mux; held at zero outside XFER so nothing passes during arbitration.
  always_comb begin
    sel_valid = 1'b0;
    sel_user  = 1'b0;
    sel_last  = 1'b0;
    sel_id    = 1'b0;
    sel_dest  = 1'b0;
    sel_data  = {DATAW{1'b0}};
    sel_strb  = {STRBW{1'b0}};
    sel_keep  = {STRBW{1'b0}};
    if (state_q == ST_XFER) begin
      sel_valid = s_axis.tvalid[grant_q];
      sel_user  = s_axis.tuser[grant_q];
      sel_last  = s_axis.tlast[grant_q];
      sel_id    = s_axis.tid[grant_q];
      sel_dest  = s_axis.tdest[grant_q];
      sel_data  = s_axis.tdata[int'(grant_q)*DATAW +: DATAW];
      sel_strb  = s_axis.tstrb[int'(grant_q)*STRBW +: STRBW];
      sel_keep  = s_axis.tkeep[int'(grant_q)*STRBW +: STRBW];
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Only the granted input sees ready, and only while transferring.
  always_comb begin
    s_ready = {NUM_SI{1'b0}};
    if (state_q == ST_XFER) begin
      s_ready[grant_q] = take;
    end else begin
      s_ready = {NUM_SI{1'b0}};
    end
  end

  assign s_axis.tready = s_ready;
  assign beat_done     = (state_q == ST_XFER) & sel_valid & take & sel_last;

  // Arbitration FSM: grant in IDLE, hold the grant until the tlast beat is accepted.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = rr_next;
          busy_d  = 1'b1;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (beat_done) begin
          last_grant_d = grant_q;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // last_grant resets to NUM_SI-1 so input 0 wins the first arbitration.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= {IDXW{1'b0}};
      last_grant_q <= IDXW'(NUM_SI - 1);
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = busy_q;

`ifdef AXIS_SW_OUTREG_EN
  localparam int PAYW = DATAW + 2*STRBW + 4;

  logic            skid_in_ready;
  logic            skid_valid;
  logic [PAYW-1:0] skid_out;

  assign take = skid_in_ready;

  axis_skid_buf #(.DATAW(PAYW)) u_skid (
    .clk       (aclk),
    .srst      (areset),
    .in_valid  (sel_valid),
    .in_ready  (skid_in_ready),
    .in_data   ({sel_data, sel_strb, sel_keep, sel_user, sel_last, sel_id, sel_dest}),
    .out_valid (skid_valid),
    .out_ready (m_axis.tready),
    .out_data  (skid_out)
  );

  assign m_axis.tvalid = skid_valid;
  assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep,
          m_axis.tuser, m_axis.tlast, m_axis.tid, m_axis.tdest} = skid_out;
`else
  assign take          = m_axis.tready;
  assign m_axis.tvalid = sel_valid;
  assign m_axis.tdata  = sel_data;
  assign m_axis.tstrb  = sel_strb;
  assign m_axis.tkeep  = sel_keep;
  assign m_axis.tuser  = sel_user;
  assign m_axis.tlast  = sel_last;
  assign m_axis.tid    = sel_id;
  assign m_axis.tdest  = sel_dest;
`endif

endmodule

// File: tb/tb_axis_switch_rr.sv
// Self-checking bench for axis_switch_rr (default build: combinational output path).
module tb_axis_switch_rr;

  localparam int N  = 3;
  localparam int DW = 24;
  localparam int SW = DW / 8;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [N-1:0] s_en;
  logic [1:0]   grant_idx;
  logic         busy;

  axis_switch_rr_if #(.N(N), .DATAW(DW)) s_if ();
  axis_switch_rr_if #(.N(1), .DATAW(DW)) m_if ();

  axis_switch_rr #(.NUM_SI(N), .DATAW(DW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_en      (s_en),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- sources: queues of packet lengths per input ----------------
  int           len_q[N][$];
  int           beat[N];
  int           pkt[N];
  logic [N-1:0] src_vld;
  logic [N-1:0] acc;
  int           gap_pct = 0;
  int           mode = 0;   // 0: ready=1, 1: toggle 1010.., 2: random
  logic         tog = 1'b0;

  function automatic logic [DW-1:0] beat_data(int i, int p, int b);
    return {4'(i), 8'(p), 12'(b)};
  endfunction

  task automatic drive_inputs();
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      if (len_q[i].size() > 0) begin
        if (!src_vld[i]) src_vld[i] = ($urandom_range(99) >= gap_pct);
        d = beat_data(i, pkt[i], beat[i]);
        s_if.tdata[i*DW +: DW] = d;
        s_if.tuser[i] = (beat[i] == 0);
        s_if.tlast[i] = (beat[i] == len_q[i][0] - 1);
        s_if.tid[i]   = pkt[i][0];
        s_if.tdest[i] = beat[i][0];
        s_if.tstrb[i*SW +: SW] = d[2:0];
        s_if.tkeep[i*SW +: SW] = 3'b111 ^ d[5:3];
      end else begin
        src_vld[i] = 1'b0;
        s_if.tdata[i*DW +: DW] = {DW{1'b0}};
        s_if.tuser[i] = 1'b0;
        s_if.tlast[i] = 1'b0;
        s_if.tid[i]   = 1'b0;
        s_if.tdest[i] = 1'b0;
        s_if.tstrb[i*SW +: SW] = {SW{1'b0}};
        s_if.tkeep[i*SW +: SW] = {SW{1'b0}};
      end
    end
    s_if.tvalid = src_vld;
    if (mode == 0) m_if.tready = 1'b1;
    else if (mode == 1) begin tog = ~tog; m_if.tready = tog; end
    else m_if.tready = 1'($urandom_range(1));
  endtask

  task automatic src_advance(logic was_reset);
    if (!was_reset) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          src_vld[i] = 1'b0;
          beat[i]++;
          if (beat[i] == len_q[i][0]) begin
            void'(len_q[i].pop_front());
            beat[i] = 0;
            pkt[i]++;
          end
        end
      end
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      len_q[i].delete();
      beat[i] = 0;
    end
    src_vld = '0;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (len_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- reference model: owner of the output, rotation pointer ----------------
  int own;     // -1 when nobody holds the output
  int lastg;
  int gidx;

  task automatic model_reset();
    own = -1; lastg = N - 1; gidx = 0;
  endtask

  task automatic model_update();
    if (areset) model_reset();
    else if (own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (lastg + k) % N;
        if (own < 0 && s_en[j] && s_if.tvalid[j]) begin own = j; gidx = j; end
      end
    end else if (s_if.tvalid[own] && m_if.tready[0] && s_if.tlast[own]) begin
      lastg = own; own = -1;
    end
  endtask

  int first_g[$];
  int first_c[$];
  int last_c[$];
  int out_idx[$];

  task automatic clear_logs();
    first_g.delete(); first_c.delete(); last_c.delete(); out_idx.delete();
  endtask

  task automatic check_cycle();
    logic           exp_mv;
    logic [63:0]    exp_pay, act_pay;
    logic [N-1:0]   exp_rdy;
    exp_mv = 1'b0; exp_pay = 64'd0; exp_rdy = '0;
    if (own >= 0) begin
      exp_mv  = s_if.tvalid[own];
      exp_pay = {30'd0, s_if.tdata[own*DW +: DW], s_if.tuser[own], s_if.tlast[own],
                 s_if.tid[own], s_if.tdest[own], s_if.tstrb[own*SW +: SW], s_if.tkeep[own*SW +: SW]};
      exp_rdy[own] = m_if.tready[0];
    end
    act_pay = {30'd0, m_if.tdata, m_if.tuser, m_if.tlast, m_if.tid, m_if.tdest, m_if.tstrb, m_if.tkeep};
    check("m_tvalid", 64'(m_if.tvalid), 64'(exp_mv));
    check("m_payload", act_pay, exp_pay);
    check("s_tready", 64'(s_if.tready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(own >= 0));
    check("grant_idx", 64'(grant_idx), 64'(gidx));
    acc = exp_rdy & s_if.tvalid;
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      if (m_if.tuser[0]) begin first_g.push_back(int'(grant_idx)); first_c.push_back(cyc); end
      if (m_if.tlast[0]) last_c.push_back(cyc);
      out_idx.push_back(int'(m_if.tdata[11:0]));
    end
  endtask

  task automatic cycle();
    logic was_reset;
    drive_inputs();
    @(negedge aclk);
    check_cycle();
    model_update();
    was_reset = areset;
    @(posedge aclk);
    #1;
    src_advance(was_reset);
    cyc++;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cycle();
    areset = 1'b0;
  endtask

  task automatic run_until_empty(string name, int bound);
    int n = 0;
    while (!all_empty() && n < bound) begin cycle(); n++; end
    check(name, 64'(all_empty()), 64'd1);
  endtask

  // ---------------- table of single-source vectors ----------------
  typedef struct {
    logic [2:0]  en, vld, last;
    logic [23:0] d;
    logic        mrdy;
    logic        exp_mv;
    logic [23:0] exp_d;
    logic [2:0]  exp_rdy;
    logic        exp_busy;
    logic [1:0]  exp_g;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{3'b111, 3'b010, 3'b000, 24'h000001, 1'b1, 1'b0, 24'h000000, 3'b000, 1'b0, 2'd0};
    tbl[1] = '{3'b111, 3'b010, 3'b000, 24'h000001, 1'b1, 1'b1, 24'h000001, 3'b010, 1'b1, 2'd1};
    tbl[2] = '{3'b111, 3'b010, 3'b000, 24'h000002, 1'b1, 1'b1, 24'h000002, 3'b010, 1'b1, 2'd1};
    tbl[3] = '{3'b111, 3'b010, 3'b000, 24'h000003, 1'b1, 1'b1, 24'h000003, 3'b010, 1'b1, 2'd1};
    tbl[4] = '{3'b111, 3'b010, 3'b010, 24'h000004, 1'b1, 1'b1, 24'h000004, 3'b010, 1'b1, 2'd1};
    tbl[5] = '{3'b111, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 24'h000000, 3'b000, 1'b0, 2'd1};

    s_en = '0; src_vld = '0; acc = '0;
    for (int i = 0; i < N; i++) begin beat[i] = 0; pkt[i] = 0; end
    s_if.tvalid = '0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = '0;
    s_if.tid = '0; s_if.tdest = '0; s_if.tstrb = '0; s_if.tkeep = '0;
    m_if.tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    model_reset();
    areset = 1'b0;

    // Reset then idle
    s_en = 3'b111;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("idle_mvalid", 64'(m_if.tvalid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_grant", 64'(grant_idx), 64'd0);
      check("idle_tready", 64'(s_if.tready), 64'd0);
    end

    // Single source, table driven
    for (int k = 0; k < 6; k++) begin
      s_en = tbl[k].en; s_if.tvalid = tbl[k].vld; s_if.tlast = tbl[k].last;
      s_if.tdata = {3{tbl[k].d}}; s_if.tuser = '0; s_if.tid = '0; s_if.tdest = '0;
      s_if.tstrb = '0; s_if.tkeep = '0; m_if.tready = tbl[k].mrdy;
      @(negedge aclk);
      check("tbl_mvalid", 64'(m_if.tvalid), 64'(tbl[k].exp_mv));
      check("tbl_mdata", 64'(m_if.tdata), 64'(tbl[k].exp_d));
      check("tbl_tready", 64'(s_if.tready), 64'(tbl[k].exp_rdy));
      check("tbl_busy", 64'(busy), 64'(tbl[k].exp_busy));
      check("tbl_grant", 64'(grant_idx), 64'(tbl[k].exp_g));
      model_update();
      @(posedge aclk);
      #1;
      cyc++;
    end

    // Round-robin fairness: 2-beat packets on every input
    do_reset();
    clear_logs();
    mode = 0; gap_pct = 0;
    for (int i = 0; i < N; i++) begin len_q[i].push_back(2); len_q[i].push_back(2); end
    run_until_empty("rr_done", 100);
    check("rr_count", 64'(first_g.size()), 64'd6);
    for (int k = 0; k < 6 && k < first_g.size(); k++) begin
      check("rr_order", 64'(first_g[k]), 64'(k % N));
      if (k > 0) check("rr_bubble", 64'(first_c[k] - last_c[k-1] - 1), 64'd1);
    end

    // Enable gating: drop s_en[0] during beat 2 of an input-0 packet
    clear_logs();
    len_q[0].push_back(4); len_q[0].push_back(4); len_q[2].push_back(2);
    for (int n = 0; n < 100 && len_q[2].size() != 0; n++) begin
      if (beat[0] == 1 && len_q[0].size() == 2) s_en[0] = 1'b0;
      cycle();
    end
    check("en_first_pkt_done", 64'(len_q[0].size()), 64'd1);
    repeat (10) cycle();
    check("en_busy_idle", 64'(busy), 64'd0);
    check("en_grants", 64'(first_g.size()), 64'd2);
    if (first_g.size() >= 2) begin
      check("en_grant0", 64'(first_g[0]), 64'd0);
      check("en_grant1", 64'(first_g[1]), 64'd2);
    end
    s_en = 3'b111;
    run_until_empty("en_drain", 100);
    check("en_regrant0", 64'(first_g.size() >= 3 ? first_g[2] : -1), 64'd0);

    // Backpressure: tready toggles during an 8-beat packet
    clear_logs();
    mode = 1; tog = 1'b0;
    len_q[1].push_back(8);
    run_until_empty("bp_done", 100);
    check("bp_beats", 64'(out_idx.size()), 64'd8);
    for (int k = 0; k < out_idx.size(); k++) check("bp_order", 64'(out_idx[k]), 64'(k));
    mode = 0;

    // Reset mid-packet at beat 3 of 6
    len_q[1].push_back(6);
    for (int n = 0; n < 50 && beat[1] != 2; n++) cycle();
    check("rst_reached_beat3", 64'(beat[1]), 64'd2);
    do_reset();
    check("rst_mvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_tready", 64'(s_if.tready), 64'd0);
    clear_sources();
    clear_logs();
    for (int i = 0; i < N; i++) len_q[i].push_back(2);
    run_until_empty("rst_drain", 100);
    check("rst_next_grant", 64'(first_g.size() > 0 ? first_g[0] : -1), 64'd0);

    // Randomised traffic against the model
    mode = 2; gap_pct = 30;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++)
        if (len_q[i].size() < 2 && $urandom_range(9) < 3) len_q[i].push_back(int'($urandom_range(5, 1)));
      if (n % 50 == 0) s_en = 3'($urandom_range(7));
      cycle();
    end
    s_en = 3'b111; mode = 0; gap_pct = 0;
    run_until_empty("rand_drain", 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
